// File: rtl/ring_shift_ctrl.sv
// ring_shift_ctrl: upstream controller for the T0..T7 one-hot ring counter.
// Issues a burst of exactly N registered shift enables per accepted start,
// reports busy/done/aborted and keeps a binary mirror of the ring position.
// Optional feature macro: ONEHOT_CHECK_EN adds ring_in/ring_err and a sticky
// one-hot/position consistency checker against the live ring outputs.
module ring_shift_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned RING_LEN = 8,
    parameter int unsigned POS_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [CNT_W-1:0]    cycles,
    output logic                shift_r,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [POS_W-1:0]    pos
`ifdef ONEHOT_CHECK_EN
    ,
    input  logic [RING_LEN-1:0] ring_in,
    output logic                ring_err
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic               shift_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;
    logic [POS_W-1:0]   pos_q;
    logic [POS_W-1:0]   pos_d;
    logic [CNT_W-1:0]   remaining_q;
    logic [CNT_W-1:0]   remaining_d;
    logic               last_shift_c;
    logic               accept_c;

    // Next ring position wraps modulo the ring length; next remaining count.
    assign pos_d        = POS_W'((32'(pos_q) + 32'd1) % RING_LEN);
    assign remaining_d  = remaining_q - CNT_W'(1);
    assign last_shift_c = (remaining_q == CNT_W'(1));
    assign accept_c     = start && !stop;

    // Control FSM with registered outputs; stop dominates start and completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            pos_q       <= '0;
            remaining_q <= '0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (cycles != '0) begin
                            state_q     <= ST_RUN;
                            remaining_q <= cycles;
                            shift_q     <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // The shift issued in this cycle always lands in the ring.
                    pos_q       <= pos_d;
                    remaining_q <= remaining_d;
                    if (stop) begin
                        state_q     <= ST_IDLE;
                        shift_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        aborted_q   <= 1'b1;
                        remaining_q <= '0;
                    end else if (last_shift_c) begin
                        state_q <= ST_IDLE;
                        shift_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    shift_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign shift_r = shift_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign pos     = pos_q;

`ifdef ONEHOT_CHECK_EN
    logic                ring_err_q;
    logic [RING_LEN-1:0] ring_exp_c;
    logic                ring_bad_c;

    // Expected ring pattern: pos 0 is the MSB, each position one bit lower.
    assign ring_exp_c = {1'b1, {(RING_LEN-1){1'b0}}} >> pos_q;
    assign ring_bad_c = (ring_in != ring_exp_c);

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ring_err_q <= 1'b0;
        end else if (ring_bad_c) begin
            ring_err_q <= 1'b1;
        end
    end

    assign ring_err = ring_err_q;
`endif

endmodule

// File: tb/tb_ring_shift_ctrl.sv
// Randomized self-checking bench for ring_shift_ctrl; expectations come from
// transaction-level arithmetic (shift count, pulse kind, position modulo 8).
module tb_ring_shift_ctrl;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned RING_LEN = 8;
    localparam int unsigned POS_W    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] cycles;
    logic             shift_r;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [POS_W-1:0] pos;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pos  = 0;

`ifdef ONEHOT_CHECK_EN
    logic [RING_LEN-1:0] ring_q;
    logic [RING_LEN-1:0] ring_in;
    logic                ring_err;
    logic                corrupt = 1'b0;

    // Behavioural ring counter: T0 is the MSB, each shift moves one bit down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       ring_q <= 8'b1000_0000;
        else if (shift_r) ring_q <= {ring_q[0], ring_q[RING_LEN-1:1]};
    end
    assign ring_in = corrupt ? 8'b1100_0000 : ring_q;
`endif

    ring_shift_ctrl #(
        .CNT_W    (CNT_W),
        .RING_LEN (RING_LEN),
        .POS_W    (POS_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .cycles   (cycles),
        .shift_r  (shift_r),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .pos      (pos)
`ifdef ONEHOT_CHECK_EN
        ,
        .ring_in  (ring_in),
        .ring_err (ring_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One start request of n shifts; optional stop during the stop_at-th shift
    // cycle and an optional ignored start in the middle of the run.
    task automatic do_run(input int n, input int stop_at, input bit spur);
        int  cnt;
        int  iter;
        bit  exp_abort;
        int  exp_cnt;
        cnt       = 0;
        iter      = 0;
        exp_abort = (stop_at >= 1) && (stop_at < n);
        exp_cnt   = exp_abort ? stop_at : n;
        @(negedge clk);
        start  = 1'b1;
        stop   = 1'b0;
        cycles = CNT_W'(n);
        forever begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            iter++;
            if (iter > n + 4) begin
                check_eq("run_timeout", 32'(iter), 32'(n + 4));
                break;
            end
            if (!shift_r) break;
            cnt++;
            check_eq("busy_in_run", 32'(busy), 32'd1);
            check_eq("pulse_in_run", 32'({done, aborted}), 32'd0);
            if (exp_abort && cnt == stop_at) stop = 1'b1;
            if (spur && cnt == 2) begin
                start  = 1'b1;
                cycles = CNT_W'(3);
            end
        end
        exp_pos = (exp_pos + exp_cnt) % RING_LEN;
        check_eq("shift_count", 32'(cnt), 32'(exp_cnt));
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("done_pulse", 32'(done), 32'(!exp_abort));
        check_eq("abort_pulse", 32'(aborted), 32'(exp_abort));
        check_eq("pos_end", 32'(pos), 32'(exp_pos));
        @(negedge clk);
        check_eq("pulse_single", 32'({done, aborted, shift_r}), 32'd0);
    endtask

    // start together with stop, then stop alone, in IDLE: nothing happens.
    task automatic idle_noise();
        @(negedge clk);
        start  = 1'b1;
        stop   = 1'b1;
        cycles = CNT_W'($urandom_range(0, 9));
        @(negedge clk);
        start = 1'b0;
        check_eq("ss_quiet", 32'({shift_r, busy, done, aborted}), 32'd0);
        @(negedge clk);
        stop = 1'b0;
        check_eq("stop_idle_quiet", 32'({shift_r, busy, done, aborted}), 32'd0);
        check_eq("ss_pos", 32'(pos), 32'(exp_pos));
    endtask

    // Async reset mid-run clears everything immediately, with no pulses.
    task automatic reset_midrun();
        @(negedge clk);
        start  = 1'b1;
        cycles = CNT_W'(10);
        @(negedge clk);
        start = 1'b0;
        check_eq("mid_started", 32'(shift_r), 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_eq("mid_rst_clear", 32'({shift_r, busy, done, aborted}), 32'd0);
        check_eq("mid_rst_pos", 32'(pos), 32'd0);
        exp_pos = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_no_resume", 32'({shift_r, busy, done, aborted}), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        cycles = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_outputs", 32'({shift_r, busy, done, aborted}), 32'd0);
        check_eq("rst_pos", 32'(pos), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_run(5, -1, 1'b0);
        do_run(10, -1, 1'b0);
        do_run(20, 3, 1'b1);
        do_run(0, -1, 1'b0);
        idle_noise();
        do_run(1, -1, 1'b0);
        do_run(255, -1, 1'b1);
        reset_midrun();
        do_run(10, -1, 1'b0);
        check_eq("wrap_pos", 32'(pos), 32'd2);

        for (int t = 0; t < 30; t++) begin
            int n;
            int s;
            n = int'($urandom_range(0, 24));
            s = ($urandom_range(0, 2) == 0 && n > 1) ? int'($urandom_range(1, n - 1)) : -1;
            if ($urandom_range(0, 5) == 0) idle_noise();
            do_run(n, s, 1'($urandom_range(0, 1)));
        end

`ifdef ONEHOT_CHECK_EN
        check_eq("ring_err_clean", 32'(ring_err), 32'd0);
        do_run(12, -1, 1'b0);
        check_eq("ring_err_12", 32'(ring_err), 32'd0);
        @(negedge clk);
        corrupt = 1'b1;
        @(negedge clk);
        corrupt = 1'b0;
        check_eq("ring_err_set", 32'(ring_err), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("ring_err_sticky", 32'(ring_err), 32'd1);
        reset = 1'b0;
        #1 check_eq("ring_err_rst", 32'(ring_err), 32'd0);
        exp_pos = 0;
        @(negedge clk);
        reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
